// File: rtl/encoder_8b10b_pkg.sv
// enc8b10b_pkg: shared definitions for the 8b/10b transmit encoder.
//   rd_t          running-disparity state (RD_NEG / RD_POS)
//   d6_rdm/d4_rdm RD- forms of the data sub-block codes, abcdei / fghj with 'a'/'f' as MSB
//   k4_rdm        K28.y 4b codes, indexed by the RD seen at the 4b step
//   plus6/plus4   RD+ form of a data code (neutral codes are shared by both RDs)
//   rd_after6/4   RD left behind by an emitted sub-block
//   a7_sel, k_valid, rev6, rev4 helper functions
package enc8b10b_pkg;

    typedef enum logic {RD_NEG = 1'b0, RD_POS = 1'b1} rd_t;

    localparam logic [4:0] K28_X      = 5'd28;
    localparam logic [2:0] K28_5_Y    = 3'd5;
    localparam logic [5:0] K28_6B_RDM = 6'b001111;
    localparam logic [3:0] A7_4B_RDM  = 4'b0111;

    function automatic logic [5:0] d6_rdm(input logic [4:0] x);
        case (x)
            5'd0:  d6_rdm = 6'b100111;  5'd1:  d6_rdm = 6'b011101;
            5'd2:  d6_rdm = 6'b101101;  5'd3:  d6_rdm = 6'b110001;
            5'd4:  d6_rdm = 6'b110101;  5'd5:  d6_rdm = 6'b101001;
            5'd6:  d6_rdm = 6'b011001;  5'd7:  d6_rdm = 6'b111000;
            5'd8:  d6_rdm = 6'b111001;  5'd9:  d6_rdm = 6'b100101;
            5'd10: d6_rdm = 6'b010101;  5'd11: d6_rdm = 6'b110100;
            5'd12: d6_rdm = 6'b001101;  5'd13: d6_rdm = 6'b101100;
            5'd14: d6_rdm = 6'b011100;  5'd15: d6_rdm = 6'b010111;
            5'd16: d6_rdm = 6'b011011;  5'd17: d6_rdm = 6'b100011;
            5'd18: d6_rdm = 6'b010011;  5'd19: d6_rdm = 6'b110010;
            5'd20: d6_rdm = 6'b001011;  5'd21: d6_rdm = 6'b101010;
            5'd22: d6_rdm = 6'b011010;  5'd23: d6_rdm = 6'b111010;
            5'd24: d6_rdm = 6'b110011;  5'd25: d6_rdm = 6'b100110;
            5'd26: d6_rdm = 6'b010110;  5'd27: d6_rdm = 6'b110110;
            5'd28: d6_rdm = 6'b001110;  5'd29: d6_rdm = 6'b101110;
            5'd30: d6_rdm = 6'b011110;  5'd31: d6_rdm = 6'b101011;
            default: d6_rdm = 6'b100111;
        endcase
    endfunction

    // y=7 returns the primary P7 code; A7 is chosen separately.
    function automatic logic [3:0] d4_rdm(input logic [2:0] y);
        case (y)
            3'd0: d4_rdm = 4'b1011;  3'd1: d4_rdm = 4'b1001;
            3'd2: d4_rdm = 4'b0101;  3'd3: d4_rdm = 4'b1100;
            3'd4: d4_rdm = 4'b1101;  3'd5: d4_rdm = 4'b1010;
            3'd6: d4_rdm = 4'b0110;  3'd7: d4_rdm = 4'b1110;
            default: d4_rdm = 4'b1011;
        endcase
    endfunction

    // K28 4b codes at RD- of the 4b step; the RD+ form is always the complement.
    function automatic logic [3:0] k4_rdm(input logic [2:0] y);
        case (y)
            3'd0: k4_rdm = 4'b1011;  3'd1: k4_rdm = 4'b0110;
            3'd2: k4_rdm = 4'b1010;  3'd3: k4_rdm = 4'b1100;
            3'd4: k4_rdm = 4'b1101;  3'd5: k4_rdm = 4'b0101;
            3'd6: k4_rdm = 4'b1001;  3'd7: k4_rdm = 4'b0111;
            default: k4_rdm = 4'b0101;
        endcase
    endfunction

    function automatic logic [2:0] ones6(input logic [5:0] c);
        ones6 = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} +
                {2'b00, c[3]} + {2'b00, c[4]} + {2'b00, c[5]};
    endfunction

    function automatic logic [2:0] ones4(input logic [3:0] c);
        ones4 = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} + {2'b00, c[3]};
    endfunction

    // Balanced codes are shared by both RDs, except 111000 whose RD+ twin is 000111.
    function automatic logic [5:0] plus6(input logic [5:0] c);
        if ((ones6(c) == 3'd3) && (c != 6'b111000)) plus6 = c;
        else                                         plus6 = ~c;
    endfunction

    // Balanced codes are shared by both RDs, except 1100 whose RD+ twin is 0011.
    function automatic logic [3:0] plus4(input logic [3:0] c);
        if ((ones4(c) == 3'd2) && (c != 4'b1100)) plus4 = c;
        else                                       plus4 = ~c;
    endfunction

    // Unbalanced codes set RD by their sign; 000111 leaves RD+, 111000 leaves RD-.
    function automatic logic rd_after6(input logic [5:0] c, input logic rd);
        if (ones6(c) > 3'd3)       rd_after6 = 1'b1;
        else if (ones6(c) < 3'd3)  rd_after6 = 1'b0;
        else if (c == 6'b000111)   rd_after6 = 1'b1;
        else if (c == 6'b111000)   rd_after6 = 1'b0;
        else                       rd_after6 = rd;
    endfunction

    // Same rule for the 4b sub-block with 0011 / 1100 as the balanced-but-decisive codes.
    function automatic logic rd_after4(input logic [3:0] c, input logic rd);
        if (ones4(c) > 3'd2)       rd_after4 = 1'b1;
        else if (ones4(c) < 3'd2)  rd_after4 = 1'b0;
        else if (c == 4'b0011)     rd_after4 = 1'b1;
        else if (c == 4'b1100)     rd_after4 = 1'b0;
        else                       rd_after4 = rd;
    endfunction

    // A7 avoids a run of five equal bits across the 6b/4b boundary.
    function automatic logic a7_sel(input logic [4:0] x, input logic rd);
        if (rd) a7_sel = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        else    a7_sel = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
    endfunction

    function automatic logic k_valid(input logic [4:0] x, input logic [2:0] y);
        k_valid = (x == K28_X) ||
                  ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) ||
                                   (x == 5'd29) || (x == 5'd30)));
    endfunction

    // Tables hold 'a' in the MSB; the line order wants 'a' in bit 0.
    function automatic logic [5:0] rev6(input logic [5:0] c);
        rev6 = {c[0], c[1], c[2], c[3], c[4], c[5]};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] c);
        rev4 = {c[0], c[1], c[2], c[3]};
    endfunction

endpackage

// File: rtl/encoder_8b10b_code_lut.sv
// encoder_code_lut: combinational 8b/10b symbol lookup.
//   i_x [4:0]      EDCBA part of the byte
//   i_y [2:0]      HGF part of the byte
//   i_k            1 = control character
//   i_rd_in        running disparity before this symbol (1 = RD+)
//   o_code10 [9:0] symbol, [5:0]=abcdei (bit0=a), [9:6]=fghj (bit6=f)
//   o_rd_next      running disparity after this symbol
//   o_k_err        unsupported K code; K28.5 is produced instead
module encoder_code_lut
    import enc8b10b_pkg::*;
(
    input  logic [4:0] i_x,
    input  logic [2:0] i_y,
    input  logic       i_k,
    input  logic       i_rd_in,
    output logic [9:0] o_code10,
    output logic       o_rd_next,
    output logic       o_k_err
);

    logic       w_k_err;
    logic       w_is_k28;
    logic [2:0] w_y_eff;
    logic [5:0] w_base6;
    logic [5:0] w_code6;
    logic       w_rd6;
    logic [3:0] w_base4;
    logic [3:0] w_code4;

    // Two-step lookup: 6b sub-block at the incoming RD, 4b sub-block at the RD it leaves.
    always_comb begin
        w_k_err  = i_k & ~k_valid(i_x, i_y);
        w_is_k28 = i_k & (w_k_err | (i_x == K28_X));
        w_y_eff  = w_k_err ? K28_5_Y : i_y;

        if (w_is_k28) w_base6 = K28_6B_RDM;
        else          w_base6 = d6_rdm(i_x);

        if (i_rd_in) w_code6 = plus6(w_base6);
        else         w_code6 = w_base6;

        w_rd6 = rd_after6(w_code6, i_rd_in);

        if (w_is_k28) begin
            w_base4 = k4_rdm(w_y_eff);
            w_code4 = w_rd6 ? ~w_base4 : w_base4;
        end else if (i_k | ((i_y == 3'd7) & a7_sel(i_x, w_rd6))) begin
            // Kx.7 always uses A7; data uses it only to break a run-of-five.
            w_base4 = A7_4B_RDM;
            w_code4 = w_rd6 ? ~w_base4 : w_base4;
        end else begin
            w_base4 = d4_rdm(i_y);
            w_code4 = w_rd6 ? plus4(w_base4) : w_base4;
        end

        o_code10  = {rev4(w_code4), rev6(w_code6)};
        o_rd_next = rd_after4(w_code4, w_rd6);
        o_k_err   = w_k_err;
    end

endmodule

// File: rtl/encoder_8b10b.sv
// encoder_8b10b: TX-side 8b/10b encoder with running-disparity tracking.
//   BitCLK_10          symbol clock
//   Reset              asynchronous active-low reset
//   TxParallel_8 [7:0] [4:0]=EDCBA, [7:5]=HGF
//   TxDataK            encode as control character
//   TxValid            byte is valid this cycle
//   TxParallel_10[9:0] registered symbol, [5:0]=abcdei (bit0=a), [9:6]=fghj
//   TxValid_10         new symbol this cycle
//   rd_out             running disparity after the last symbol (1 = RD+)
//   code_error         one-cycle pulse with a symbol that replaced an unsupported K code
// Parameter RD_INIT: running disparity after reset.
// Build option ENC_IDLE_K285_EN: idle cycles emit K28.5 instead of holding the line.
module encoder_8b10b
    import enc8b10b_pkg::*;
#(
    parameter logic RD_INIT = 1'b0
)
(
    input  logic       BitCLK_10,
    input  logic       Reset,
    input  logic [7:0] TxParallel_8,
    input  logic       TxDataK,
    input  logic       TxValid,
    output logic [9:0] TxParallel_10,
    output logic       TxValid_10,
    output logic       rd_out,
    output logic       code_error
);

    logic [9:0] r_code;
    logic       r_valid;
    logic       r_err;
    rd_t        r_rd;

    logic       w_emit;
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k;
    logic       w_rd_cur;
    logic [9:0] w_code10;
    logic       w_rd_next;
    logic       w_k_err;

    assign w_rd_cur = (r_rd == RD_POS);

    // Choose what is encoded this cycle: the offered byte, or an idle comma when enabled.
    always_comb begin
`ifdef ENC_IDLE_K285_EN
        w_emit = 1'b1;
        if (TxValid) begin
            w_x = TxParallel_8[4:0];
            w_y = TxParallel_8[7:5];
            w_k = TxDataK;
        end else begin
            w_x = K28_X;
            w_y = K28_5_Y;
            w_k = 1'b1;
        end
`else
        w_emit = TxValid;
        w_x    = TxParallel_8[4:0];
        w_y    = TxParallel_8[7:5];
        w_k    = TxDataK;
`endif
    end

    encoder_code_lut u_lut (
        .i_x       (w_x),
        .i_y       (w_y),
        .i_k       (w_k),
        .i_rd_in   (w_rd_cur),
        .o_code10  (w_code10),
        .o_rd_next (w_rd_next),
        .o_k_err   (w_k_err)
    );

    // Output and disparity registers; RD only advances when a symbol leaves.
    always_ff @(posedge BitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            r_code  <= 10'h000;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= rd_t'(RD_INIT);
        end else if (w_emit) begin
            r_code  <= w_code10;
            r_valid <= 1'b1;
            r_err   <= w_k_err;
            r_rd    <= rd_t'(w_rd_next);
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign TxParallel_10 = r_code;
    assign TxValid_10    = r_valid;
    assign code_error    = r_err;
    assign rd_out        = w_rd_cur;

endmodule

// File: tb/tb_encoder_8b10b.sv
// tb_encoder_8b10b: directed vector table, reset/idle sequences and a decoding scoreboard
// that round-trips every data byte and every supported K code.
module tb_encoder_8b10b;

    logic       BitCLK_10;
    logic       Reset;
    logic [7:0] TxParallel_8;
    logic       TxDataK;
    logic       TxValid;
    logic [9:0] TxParallel_10;
    logic       TxValid_10;
    logic       rd_out;
    logic       code_error;

    int n_total = 0;
    int n_pass  = 0;

    encoder_8b10b #(.RD_INIT(1'b0)) dut (
        .BitCLK_10     (BitCLK_10),
        .Reset         (Reset),
        .TxParallel_8  (TxParallel_8),
        .TxDataK       (TxDataK),
        .TxValid       (TxValid),
        .TxParallel_10 (TxParallel_10),
        .TxValid_10    (TxValid_10),
        .rd_out        (rd_out),
        .code_error    (code_error)
    );

    initial BitCLK_10 = 1'b0;
    always #5 BitCLK_10 = ~BitCLK_10;

    typedef struct {
        logic [7:0] data;
        logic       k;
        logic [9:0] code;
        logic       rd;
        logic       err;
    } vec_t;

    vec_t vecs [13];

    // Reference code tables in abcdei / fghj order, 'a' / 'f' as MSB.
    localparam logic [5:0] M6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] P6 [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] M4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                      4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] P4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                      4'b0010, 4'b1010, 4'b0110, 4'b0001};
    // K28.y 4b codes keyed by the RD in front of the whole symbol.
    localparam logic [3:0] KM4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [3:0] KP4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                       4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                          8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step(input logic [7:0] d, input logic k, input logic v);
        @(negedge BitCLK_10);
        TxParallel_8 = d;
        TxDataK      = k;
        TxValid      = v;
        Reset        = 1'b1;
        @(posedge BitCLK_10);
        #1;
    endtask

    // Reset is asserted here and released by the next step().
    task automatic hold_reset();
        @(negedge BitCLK_10);
        Reset   = 1'b0;
        TxValid = 1'b0;
        repeat (2) @(negedge BitCLK_10);
    endtask

    function automatic logic rd6_rule(input logic [5:0] s, input logic rd);
        int n = $countones(s);
        if (n > 3)               return 1'b1;
        else if (n < 3)          return 1'b0;
        else if (s == 6'b000111) return 1'b1;
        else if (s == 6'b111000) return 1'b0;
        else                     return rd;
    endfunction

    function automatic logic rd4_rule(input logic [3:0] s, input logic rd);
        int n = $countones(s);
        if (n > 2)             return 1'b1;
        else if (n < 2)        return 1'b0;
        else if (s == 4'b0011) return 1'b1;
        else if (s == 4'b1100) return 1'b0;
        else                   return rd;
    endfunction

    // Receiver-side model: decode a line symbol and check its disparity against rd_in.
    function automatic void decode(input logic [9:0] sym, input logic rd_in,
                                   output logic [7:0] dbyte, output logic k_o,
                                   output logic dec_err, output logic disp_err,
                                   output logic rd_o);
        logic [5:0] s6;
        logic [3:0] s4;
        logic [4:0] x;
        logic [2:0] y;
        logic       k28, found, found4, rd6, a7_ok, kx7;
        s6 = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
        s4 = {sym[6], sym[7], sym[8], sym[9]};
        x = 5'd0; y = 3'd0; k28 = 1'b0; found = 1'b0; found4 = 1'b0;
        dec_err = 1'b0; disp_err = 1'b0; k_o = 1'b0;
        if (s6 == (rd_in ? 6'b110000 : 6'b001111)) begin
            k28 = 1'b1; x = 5'd28; found = 1'b1;
        end else if (s6 == (rd_in ? 6'b001111 : 6'b110000)) begin
            k28 = 1'b1; x = 5'd28; found = 1'b1; disp_err = 1'b1;
        end else begin
            for (int i = 0; i < 32; i++)
                if (s6 == (rd_in ? P6[i] : M6[i])) begin x = 5'(i); found = 1'b1; end
            if (!found)
                for (int i = 0; i < 32; i++)
                    if (s6 == (rd_in ? M6[i] : P6[i])) begin
                        x = 5'(i); found = 1'b1; disp_err = 1'b1;
                    end
        end
        if (!found) dec_err = 1'b1;
        rd6 = rd6_rule(s6, rd_in);
        if (k28) begin
            k_o = 1'b1;
            for (int j = 0; j < 8; j++)
                if (s4 == (rd_in ? KP4[j] : KM4[j])) begin y = 3'(j); found4 = 1'b1; end
        end else begin
            a7_ok = rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                        : (x == 5'd17 || x == 5'd18 || x == 5'd20);
            kx7   = (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);
            if (s4 == (rd6 ? 4'b1000 : 4'b0111)) begin
                y = 3'd7; found4 = 1'b1;
                if (kx7) k_o = 1'b1;
                else if (!a7_ok) dec_err = 1'b1;
            end else begin
                for (int j = 0; j < 8; j++)
                    if (s4 == (rd6 ? P4[j] : M4[j])) begin y = 3'(j); found4 = 1'b1; end
                if (found4 && y == 3'd7 && a7_ok) dec_err = 1'b1;
            end
        end
        if (!found4) dec_err = 1'b1;
        dbyte = {y, x};
        rd_o  = rd4_rule(s4, rd6);
    endfunction

    initial begin
        logic [7:0] d, got_byte;
        logic       k, got_k, de, pe, sb_rd, nrd;

        vecs[0]  = '{8'h00, 1'b0, 10'h0B9, 1'b0, 1'b0};  // D.0.0 RD-
        vecs[1]  = '{8'hBC, 1'b1, 10'h17C, 1'b1, 1'b0};  // K28.5 RD-
        vecs[2]  = '{8'hBC, 1'b1, 10'h283, 1'b0, 1'b0};  // K28.5 RD+
        vecs[3]  = '{8'hB5, 1'b0, 10'h155, 1'b0, 1'b0};  // D.21.5 neutral
        vecs[4]  = '{8'h05, 1'b1, 10'h17C, 1'b1, 1'b1};  // K5.0 invalid -> K28.5
        vecs[5]  = '{8'hBC, 1'b1, 10'h283, 1'b0, 1'b0};  // error pulse gone
        vecs[6]  = '{8'hF1, 1'b0, 10'h3B1, 1'b1, 1'b0};  // D.17.7 A7 at RD-
        vecs[7]  = '{8'hEB, 1'b0, 10'h04B, 1'b0, 1'b0};  // D.11.7 A7 at RD+
        vecs[8]  = '{8'hEB, 1'b0, 10'h1CB, 1'b1, 1'b0};  // D.11.7 P7 at RD-
        vecs[9]  = '{8'hF7, 1'b1, 10'h3A8, 1'b1, 1'b0};  // K23.7 RD+
        vecs[10] = '{8'h00, 1'b0, 10'h346, 1'b1, 1'b0};  // D.0.0 RD+
        vecs[11] = '{8'hFC, 1'b1, 10'h383, 1'b1, 1'b0};  // K28.7 RD+
        vecs[12] = '{8'hFF, 1'b1, 10'h283, 1'b0, 1'b1};  // K31.7 invalid at RD+

        Reset = 1'b0; TxParallel_8 = 8'h00; TxDataK = 1'b0; TxValid = 1'b0;
        #3;
        chk("reset_code", 32'(TxParallel_10), 32'h000);
        chk("reset_valid", 32'(TxValid_10), 32'h0);
        chk("reset_rd", 32'(rd_out), 32'h0);
        chk("reset_err", 32'(code_error), 32'h0);
        hold_reset();

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].data, vecs[i].k, 1'b1);
            chk($sformatf("vec%0d_code", i), 32'(TxParallel_10), 32'(vecs[i].code));
            chk($sformatf("vec%0d_valid", i), 32'(TxValid_10), 32'h1);
            chk($sformatf("vec%0d_rd", i), 32'(rd_out), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_err", i), 32'(code_error), 32'(vecs[i].err));
        end

        // Mid-stream asynchronous reset while RD+ with a byte in flight.
        step(8'hBC, 1'b1, 1'b1);
        chk("pre_reset_rd", 32'(rd_out), 32'h1);
        #2;
        TxParallel_8 = 8'h00; TxDataK = 1'b0; TxValid = 1'b1;
        Reset = 1'b0;
        #1;
        chk("async_rd", 32'(rd_out), 32'h0);
        chk("async_valid", 32'(TxValid_10), 32'h0);
        chk("async_code", 32'(TxParallel_10), 32'h000);
`ifdef ENC_IDLE_K285_EN
        step(8'h00, 1'b0, 1'b0);
        chk("idle1_code", 32'(TxParallel_10), 32'h17C);
        chk("idle1_valid", 32'(TxValid_10), 32'h1);
        step(8'h00, 1'b0, 1'b0);
        chk("idle2_code", 32'(TxParallel_10), 32'h283);
        chk("idle2_rd", 32'(rd_out), 32'h0);
`else
        step(8'hBC, 1'b1, 1'b1);
        chk("post_reset_code", 32'(TxParallel_10), 32'h17C);
        for (int i = 0; i < 2; i++) begin
            step(8'h00, 1'b0, 1'b0);
            chk("idle_valid", 32'(TxValid_10), 32'h0);
            chk("idle_hold_code", 32'(TxParallel_10), 32'h17C);
            chk("idle_hold_rd", 32'(rd_out), 32'h1);
        end
`endif

        // Scoreboard: every data byte and every supported K code, twice, through the decoder model.
        hold_reset();
        sb_rd = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int b = 0; b < 268; b++) begin
                if (b < 256) begin d = 8'(b); k = 1'b0; end
                else begin d = KLIST[b - 256]; k = 1'b1; end
                step(d, k, 1'b1);
                decode(TxParallel_10, sb_rd, got_byte, got_k, de, pe, nrd);
                chk($sformatf("rt_%0h_k%0d", d, k),
                    32'({TxValid_10, code_error, de, pe, got_k, got_byte}),
                    32'({1'b1, 1'b0, 1'b0, 1'b0, k, d}));
                chk($sformatf("rt_rd_%0h_k%0d", d, k), 32'(rd_out), 32'(nrd));
                sb_rd = nrd;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
